// File: rtl/fetch_stage.sv
// Instruction fetch sequencer: owns the fetch PC, reads the synchronous-read
// instruction RAM, and hands captured words to decode over valid/ready.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [29:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_dout,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fault
);

  typedef enum logic [1:0] {RST, REQ, RESP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, pc_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt;
  logic        valid_nxt, fault_nxt;

  assign mem_addr = fetch_pc[31:2];
  assign mem_re   = (state == REQ) | ((state == HOLD) & inst_ready);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = fetch_pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    valid_nxt   = inst_valid;
    fault_nxt   = fault;
    case (state)
      RST:  state_nxt = REQ;
      REQ:  state_nxt = RESP;
      RESP: begin
        inst_nxt    = mem_dout;
        inst_pc_nxt = fetch_pc;
        valid_nxt   = 1'b1;
        pc_nxt      = fetch_pc + 32'd4;
        state_nxt   = HOLD;
      end
      HOLD: begin
        // The read for fetch_pc goes out this cycle; the word lands in RESP.
        if (inst_ready) begin
          valid_nxt = 1'b0;
          state_nxt = RESP;
        end
      end
      default: state_nxt = RST;
    endcase
    // Redirect overrides everything, dropping any word in flight.
    if (redirect) begin
      pc_nxt    = {redirect_target[31:2], 2'b00};
      valid_nxt = 1'b0;
      state_nxt = REQ;
      if (redirect_target[1:0] != 2'b00) fault_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RST;
      fetch_pc   <= RESET_PC;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= pc_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= valid_nxt;
      fault      <= fault_nxt;
    end
  end

endmodule
